// File: rtl/card_dealer.sv
// Finite-shoe card source: deals ranks 1..13 on request, tracking per-rank counts until shuffled.
// Define CARD_DEALER_FIXED_ORDER_EN to deal in ascending rank order instead of LFSR-selected ranks.
module card_dealer #(
  parameter int DECKS = 1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       deal_req,
  input  logic       shuffle,
  output logic [3:0] new_card,
  output logic       card_valid,
  output logic       deck_empty,
  output logic [7:0] cards_left
);

  // Counter width is sized so that 4 x DECKS fits for every legal shoe size.
  localparam int            CW         = $clog2(4 * DECKS + 1);
  localparam logic [CW-1:0] FULL_RANK  = CW'(4 * DECKS);
  localparam logic [7:0]    FULL_SHOE  = 8'(52 * DECKS);
  localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {IDLE, SEARCH, PRESENT} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cand_reg, cand_next;
  logic [15:0]   lfsr_reg;
  logic          lfsr_fb;
  logic [3:0]    lfsr_cand;
  logic [3:0]    idle_cand;
  logic [CW-1:0] count_reg [1:13];
  logic [15:0]   nonzero;
  logic          hit;

  assign lfsr_fb   = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign lfsr_cand = (lfsr_reg[3:0] < 4'd13) ? (lfsr_reg[3:0] + 4'd1)
                                             : (lfsr_reg[3:0] - 4'd12);

`ifdef CARD_DEALER_FIXED_ORDER_EN
  assign idle_cand = 4'd1;
`else
  assign idle_cand = lfsr_cand;
`endif

  // Per-rank availability, indexed directly by rank; unused encodings read as empty.
  assign nonzero[0]     = 1'b0;
  assign nonzero[15:14] = 2'b00;
  generate
    for (genvar gi = 1; gi <= 13; gi++) begin : g_nonzero
      assign nonzero[gi] = (count_reg[gi] != '0);
    end
  endgenerate

  assign hit = nonzero[cand_reg];

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_reg <= IDLE;
      cand_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    if (shuffle) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (deal_req && !deck_empty) begin
            state_next = SEARCH;
            cand_next  = idle_cand;
          end
        end
        SEARCH: begin
          if (hit) begin
            state_next = PRESENT;
          end else begin
            cand_next = (cand_reg == 4'd13) ? 4'd1 : (cand_reg + 4'd1);
          end
        end
        PRESENT: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The hit is committed on leaving PRESENT so counts, outputs and the pulse change together.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 1; i <= 13; i++) count_reg[i] <= FULL_RANK;
    end else if (shuffle) begin
      for (int i = 1; i <= 13; i++) count_reg[i] <= FULL_RANK;
    end else if (state_reg == PRESENT) begin
      for (int i = 1; i <= 13; i++) begin
        if (cand_reg == 4'(i)) count_reg[i] <= count_reg[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      lfsr_reg   <= LFSR_SEED;
      new_card   <= 4'd0;
      card_valid <= 1'b0;
      deck_empty <= 1'b0;
      cards_left <= FULL_SHOE;
    end else begin
      lfsr_reg   <= shuffle ? LFSR_SEED : {lfsr_reg[14:0], lfsr_fb};
      card_valid <= 1'b0;
      if (shuffle) begin
        new_card   <= 4'd0;
        deck_empty <= 1'b0;
        cards_left <= FULL_SHOE;
      end else if (state_reg == PRESENT) begin
        new_card   <= cand_reg;
        card_valid <= 1'b1;
        cards_left <= cards_left - 8'd1;
        deck_empty <= (cards_left == 8'd1);
      end
    end
  end

endmodule
